// File: rtl/bpu_pkg.sv
// Shared types for the IF-stage branch predictor: counter encodings, BTB entry
// layout and the 2-bit saturating counter update.
package bpu_pkg;

  localparam int BPU_XLEN     = 32;
  localparam int BPU_IDX_BITS = 4;
  localparam int BPU_TAG_W    = BPU_XLEN - BPU_IDX_BITS - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    logic [BPU_XLEN-1:0]  target;
    cnt_e                 cnt;
  } bpu_entry_t;

  function automatic cnt_e sat_update(input cnt_e cnt, input logic taken);
    cnt_e r;
    r = cnt;
    if (taken && (cnt != ST))
      r = cnt_e'(cnt + 2'd1);
    else if (!taken && (cnt != SNT))
      r = cnt_e'(cnt - 2'd1);
    return r;
  endfunction

endpackage

// File: rtl/bpu_btb_table.sv
// Direct-mapped BTB storage: one combinational lookup port and one
// read-modify-write training port. Lookup sees pre-edge contents on collision.
module bpu_btb_table
  import bpu_pkg::*;
#(
  parameter int         IDX_BITS = BPU_IDX_BITS,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_BITS-1:0]  rd_idx,
  output bpu_entry_t           rd_entry,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_idx,
  input  logic [BPU_TAG_W-1:0] wr_tag,
  input  logic [BPU_XLEN-1:0]  wr_target,
  input  logic                 wr_taken,
  input  logic                 wr_jalx
);

  localparam int ENTRIES = 1 << IDX_BITS;

  bpu_entry_t mem [ENTRIES];
  bpu_entry_t cur;
  bpu_entry_t nxt;
  logic       cur_hit;
  logic       we;

  assign rd_entry = mem[rd_idx];
  assign cur      = mem[wr_idx];
  assign cur_hit  = cur.valid && (cur.tag == wr_tag);

  // Hits train in place; taken misses evict whatever occupies the slot.
  always_comb begin
    nxt = cur;
    we  = 1'b0;
    if (wr_en) begin
      if (cur_hit) begin
        we      = 1'b1;
        nxt.cnt = sat_update(cur.cnt, wr_taken);
        if (wr_taken)
          nxt.target = wr_target;
      end else if (wr_taken) begin
        we         = 1'b1;
        nxt.valid  = 1'b1;
        nxt.tag    = wr_tag;
        nxt.target = wr_target;
        nxt.cnt    = wr_jalx ? ST : cnt_e'(CNT_INIT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i].valid  <= 1'b0;
        mem[i].tag    <= '0;
        mem[i].target <= '0;
        mem[i].cnt    <= cnt_e'(CNT_INIT);
      end
    end else if (we) begin
      mem[wr_idx] <= nxt;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: BTB lookup for the fetch PC, training from EX
// resolution, and mispredict/redirect generation. BPU_PERF_CNT_EN adds event counters.
module branch_predictor
  import bpu_pkg::*;
#(
  parameter int         DATA_WITDH = BPU_XLEN,
  parameter int         IDX_BITS   = BPU_IDX_BITS,
  parameter logic [1:0] CNT_INIT   = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WITDH-1:0] if_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [DATA_WITDH-1:0] pred_target,
  input  logic                  ex_valid,
  input  logic [3:0]            ex_branch,
  input  logic                  ex_jalx,
  input  logic                  ex_taken,
  input  logic [DATA_WITDH-1:0] ex_pc,
  input  logic [DATA_WITDH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic [DATA_WITDH-1:0] ex_pred_target,
  output logic                  mispredict,
  output logic [DATA_WITDH-1:0] redirect_pc
`ifdef BPU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts
`endif
);

  logic       ctl;
  bpu_entry_t rd_entry;
  logic       unused_branch_bits;

  // Only bit 3 of the branch code matters here; the rest selects the compare op in EX.
  assign unused_branch_bits = &{1'b0, ex_branch[2:0]};

  assign ctl = ex_valid && (ex_branch[3] || ex_jalx);

  bpu_btb_table #(
    .IDX_BITS (IDX_BITS),
    .CNT_INIT (CNT_INIT)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (if_pc[IDX_BITS+1:2]),
    .rd_entry  (rd_entry),
    .wr_en     (ctl),
    .wr_idx    (ex_pc[IDX_BITS+1:2]),
    .wr_tag    (ex_pc[DATA_WITDH-1:IDX_BITS+2]),
    .wr_target (ex_target),
    .wr_taken  (ex_taken),
    .wr_jalx   (ex_jalx)
  );

  assign pred_hit    = !rst && rd_entry.valid && (rd_entry.tag == if_pc[DATA_WITDH-1:IDX_BITS+2]);
  assign pred_taken  = pred_hit && rd_entry.cnt[1];
  assign pred_target = pred_taken ? rd_entry.target : if_pc + DATA_WITDH'(4);

  assign mispredict  = !rst && ctl &&
                       ((ex_pred_taken != ex_taken) ||
                        (ex_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = (ex_taken && !rst) ? ex_target : ex_pc + DATA_WITDH'(4);

`ifdef BPU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (ctl)
        perf_branches <= perf_branches + 32'd1;
      if (mispredict)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage counterpart of the EX branch-resolve logic in the 5-stage RV32 core.
- Predicts taken/target for the fetch PC from a direct-mapped BTB with 2-bit saturating counters.
- Trains on the taken/target outcome EX resolves, and flags mispredictions with a redirect PC.
- Output feeds the IF next-PC mux and the IF/ID flush logic.

Parameters:
- DATA_WITDH, 32, PC/target width.
- IDX_BITS, 4, log2 of table entries (16 entries).
- CNT_INIT, 2'b01, counter value written on allocation (weakly not-taken).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_pc  input  DATA_WITDH  current fetch PC.
- pred_hit  output  1  valid BTB entry with matching tag.
- pred_taken  output  1  pred_hit and counter[1]==1.
- pred_target  output  DATA_WITDH  predicted target; if_pc+4 when pred_taken==0.
- ex_valid  input  1  EX holds a real (non-bubble) instruction.
- ex_branch  input  4  EX branch code; bit3 marks a conditional branch.
- ex_jalx  input  1  jal/jalr in EX.
- ex_taken  input  1  resolved taken from the EX branch unit.
- ex_pc  input  DATA_WITDH  PC of the EX instruction.
- ex_target  input  DATA_WITDH  resolved target.
- ex_pred_taken  input  1  prediction carried down the pipe with this instruction.
- ex_pred_target  input  DATA_WITDH  predicted target carried down the pipe.
- mispredict  output  1  redirect request to IF plus flush of IF/ID and ID/EX.
- redirect_pc  output  DATA_WITDH  correct next PC.

Behaviour:
- Index = pc[IDX_BITS+1:2]. Tag = pc[DATA_WITDH-1:IDX_BITS+2]. Per entry: valid, tag, target, 2-bit counter.
- Lookup is combinational from registered state, 0-cycle latency. A same-cycle update to the same index is not bypassed: lookup returns the old contents.
- Control instruction (ctl): ex_valid && (ex_branch[3] || ex_jalx).
- Update at the rising clk edge, only when ctl.
- Hit (valid and tag match):
  - Taken: counter saturating +1 (stops at 11); target <= ex_target.
  - Not taken: counter saturating -1 (stops at 00).
- Miss:
  - Taken: allocate (overwrite) the entry; valid=1, tag, target; counter = ex_jalx ? 2'b11 : CNT_INIT.
  - Not taken: no change.
- mispredict (combinational) = ctl && (ex_pred_taken != ex_taken || (ex_taken && ex_pred_target != ex_target)).
- redirect_pc = ex_taken ? ex_target : ex_pc+4. Sum wraps modulo 2^DATA_WITDH.
- Non-control instruction with ex_valid=1: never mispredicts, never updates. Those have ex_pred_taken==0 by construction, since the predictor only allocates on taken control instructions.
- ex_valid=0: no update; mispredict=0.
- Reset (async, any time including mid-update):
  - All valid bits 0, counters CNT_INIT, tags/targets 0.
  - Outputs while rst asserted: pred_hit=0, pred_taken=0, pred_target=if_pc+4, mispredict=0, redirect_pc=ex_pc+4.
  - First update is honoured on the first clk edge after rst deasserts.

Optional Feature:
- Macro BPU_PERF_CNT_EN.
- Defined:
  - Adds 32-bit output perf_branches, counting ctl events.
  - Adds 32-bit output perf_mispredicts, counting mispredict events.
  - Both async-reset to 0, wrap at 2^32.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package bpu_pkg:
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - Entry struct {valid, tag, target, cnt}.
  - Function sat_update(cnt, taken).
- One natural sub-module: bpu_btb_table. It holds the register array with async reset, 1 read port and 1 write port, read-old-on-collision.
- Top level keeps the mispredict/redirect logic and the perf counters.

Test Plan:
- After reset, if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
- Allocation and lookup:
  - Stimulus: EX conditional branch at 0x100, taken, ex_target=0x80, ex_pred_taken=0.
  - Same cycle: mispredict=1, redirect_pc=0x80.
  - Next cycle: if_pc=0x100 -> pred_hit=1, pred_taken=0 (WNT).
  - After a second taken update: pred_taken=1, pred_target=0x80.
- Saturation: 4 taken then 1 not-taken at 0x100 -> counter goes 11 -> 10, pred_taken still 1. Another 2 not-taken -> 00, then stays 00 on a further not-taken.
- jal at 0x200 to 0x400, miss -> allocated with counter 11; next lookup of 0x200 gives pred_taken=1, pred_target=0x400.
- Aliasing and collision:
  - 0x100 and 0x140 share index 0 with different tags.
  - Allocating 0x140 evicts 0x100; lookup of 0x100 -> pred_hit=0.
  - Lookup of 0x140 in the same cycle as its own allocation -> old contents (miss).
- Reset asserted mid-stream while ex_valid=1 and a taken update is pending -> no write occurs; all entries invalid; mispredict=0 while rst=1.
- With BPU_PERF_CNT_EN: 5 branches including 2 mispredicts -> perf_branches=5, perf_mispredicts=2.
